// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit: states, opcodes,
// ALU codes, mux selects and the decoded instruction class.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_LOAD, C_STORE, C_BR_EQ, C_BR_NE, C_IMM, C_JUMP, C_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;

    localparam logic [1:0] ASB_RT     = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // ALU operation for the immediate-arithmetic group; addi falls through to add.
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_SLTI: return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_op_class.sv
// Combinational opcode-to-class decoder; extended opcodes classify as illegal
// unless EN_EXT is set.
module mc_op_class
    import mc_ctrl_pkg::*;
#(
    parameter bit EN_EXT = 1'b1
) (
    input  logic [5:0] op,
    output op_class_t  cls
);

    always_comb begin
        cls = C_ILLEGAL;
        case (op)
            OP_RTYPE:               cls = C_RTYPE;
            OP_LW:                  cls = C_LOAD;
            OP_SW:                  cls = C_STORE;
            OP_BEQ:                 cls = C_BR_EQ;
            OP_J:                   cls = C_JUMP;
            OP_ADDI:                cls = C_IMM;
            OP_BNE:                 cls = EN_EXT ? C_BR_NE : C_ILLEGAL;
            OP_ANDI, OP_ORI, OP_SLTI: cls = EN_EXT ? C_IMM : C_ILLEGAL;
            default:                cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback and drives the datapath strobes, stalling on mem_ready.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter bit EN_EXT   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                branch_ne,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                instr_done,
    output logic                illegal
);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] op_sel;
    logic [2:0] alu_op_c;
    op_class_t  cls;

    // op is only valid during DECODE; later states classify the latched copy.
    assign op_sel = (state_q == S_DECODE) ? op : op_q;

    mc_op_class #(.EN_EXT(EN_EXT)) u_op_class (
        .op  (op_sel),
        .cls (cls)
    );

    assign alu_op = ALU_OP_W'(alu_op_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        pc_src     = PC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = ASB_RT;
        alu_op_c   = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ASB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = ASB_IMM_SH;
                op_d      = op;
                case (cls)
                    C_RTYPE:          state_d = S_R_EXEC;
                    C_LOAD, C_STORE:  state_d = S_MEM_ADDR;
                    C_BR_EQ, C_BR_NE: state_d = S_BRANCH;
                    C_JUMP:           state_d = S_JUMP;
                    C_IMM:            state_d = S_I_EXEC;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_IMM;
                state_d   = (cls == C_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op_c  = ALU_FUNCT;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_IMM;
                alu_op_c  = imm_alu_op(op_q);
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op_c   = ALU_SUB;
                pc_src     = PC_ALUOUT;
                branch     = (cls == C_BR_EQ);
                branch_ne  = (cls == C_BR_NE);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control unit for the MIPS core, replacing the single-cycle opcode decoder. A Moore/Mealy FSM sequences each instruction through fetch, decode, execute, memory and writeback steps, driving datapath strobes one step per cycle. It supports wait-stated memory through a ready handshake, an extended opcode set selectable by parameter, and illegal-opcode flagging. It sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

## Interface
- ALU_OP_W, 3, width of alu_op; legal values are 3 or more, and upper bits are zero-filled.
- EN_EXT, 1, when 1 decodes bne/andi/ori/slti; when 0 those opcodes are illegal.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  opcode, IR[31:26], sampled in DECODE.
- mem_ready  in  1  memory has completed the current access.
- mem_read, mem_write  out  1  memory access request, held until mem_ready.
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC write.
- branch, branch_ne  out  1  conditional PC write on zero / on not-zero.
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target.
- alu_src_a  out  1  0 PC, 1 rs.
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op  out  ALU_OP_W  0 add, 1 sub, 2 R-type funct, 3 and, 4 or, 5 slt.
- reg_dst, mem_to_reg, reg_write  out  1  register-file write control.
- instr_done  out  1  one-cycle pulse in the final cycle of every instruction.
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- Reset puts the FSM in IDLE, where every output is 0. IDLE goes to FETCH unconditionally on the next clock.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00. ir_write and pc_write equal mem_ready (Mealy). The FSM stays in FETCH while mem_ready=0 and goes to DECODE when it is 1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target into ALUOut). Next state by op:
  - 000000 goes to R_EXEC.
  - 100011 and 101011 go to MEM_ADDR.
  - 000100 goes to BRANCH.
  - 000010 goes to JUMP.
  - 001000 goes to I_EXEC.
  - With EN_EXT=1, 000101 goes to BRANCH, and 001100, 001101, 001010 go to I_EXEC.
  - Any other opcode: illegal=1 and instr_done=1 for this cycle, then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Waits for mem_ready; instr_done=mem_ready. Goes to FETCH on ready.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=funct. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, instr_done=1. Goes to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10; alu_op is add/and/or/slt for addi/andi/ori/slti. The opcode is latched in DECODE into an internal op_q register, which is also used by MEM_ADDR and BRANCH. Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01. Asserts branch for beq or branch_ne for bne (never both); instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1. Goes to FETCH.
- Any output not listed for a state is 0.

## Timing
- Cycle counts with zero wait-states (mem_ready=1): lw 5; sw, R-type, addi/andi/ori/slti 4; beq, bne, j 3; illegal 2.
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. Request outputs stay stable while waiting.
- mem_ready is ignored in every state other than FETCH, MEM_RD and MEM_WR.
- rst_n asserted mid-instruction forces IDLE and all outputs to 0 immediately (asynchronously). Any pending memory request is abandoned.
- The first fetch request appears in the second cycle after rst_n deasserts.
- op only needs to be valid in the DECODE cycle.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J;
  - ALU_ADD … ALU_SLT codes;
  - the alu_src_b and pc_src encodings.
- Sub-module mc_op_class: combinational op to instruction class (RTYPE, LOAD, STORE, BR_EQ, BR_NE, IMM, JUMP, ILLEGAL), honoring EN_EXT. The FSM branches on class only.

## Test plan
- Reset, then lw (op=100011) with mem_ready=1 -> IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. reg_write=1 and mem_to_reg=1 only in MEM_WB; instr_done pulses once.
- sw with mem_ready low for 3 cycles in MEM_WR -> mem_write=1 and i_or_d=1 held for 4 cycles; instr_done coincides with mem_ready; no reg_write.
- FETCH with 2 wait cycles -> ir_write and pc_write are 0 for 2 cycles, then 1 for exactly one cycle.
- bne (000101) with EN_EXT=1 -> 3-cycle sequence, branch_ne=1, branch=0, alu_op=1. With EN_EXT=0 -> illegal=1 in DECODE, then FETCH.
- ori (001101) -> alu_op=4 in I_EXEC, reg_write=1 with reg_dst=0 in I_WB. slti -> alu_op=5. Op 111111 -> illegal pulse.
- rst_n pulsed low during MEM_RD -> all outputs 0 asynchronously; after release, IDLE then FETCH, and the next instruction completes correctly.
